// File: rtl/mips_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mips_pkg : op and FSM state encodings for the MULT/DIV unit      |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
package mips_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } md_state_t;

endpackage
`default_nettype wire

// File: rtl/muldiv_sign_fix.sv
`default_nettype none
// +------------------------------------------------------------------+
// | muldiv_sign_fix : conditional two's-complement negation          |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
module muldiv_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_val,
  input  logic             i_neg,
  output logic [WIDTH-1:0] o_val
);

  assign o_val = i_neg ? (~i_val + {{(WIDTH-1){1'b0}}, 1'b1}) : i_val;

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | muldiv_unit : iterative MIPS MULT/MULTU/DIV/DIVU with HI/LO      |
// | Optional div_zero output: define MULDIV_DIVZERO_FLAG_EN          |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
module muldiv_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
`ifdef MULDIV_DIVZERO_FLAG_EN
  output logic             div_zero,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH);

  md_state_t          r_state;
  logic               r_busy, r_done;
  logic               r_is_div, r_neg_q, r_neg_r, r_dz;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_m, r_hi_acc, r_lo_acc;
  logic [WIDTH-1:0]   r_hi, r_lo;
`ifdef MULDIV_DIVZERO_FLAG_EN
  logic               r_div_zero;
`endif

  logic               w_signed, w_a_neg, w_b_neg;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_addend, w_diff, w_quo, w_rem;
  logic [WIDTH:0]     w_sum, w_shl;
  logic               w_ge;
  logic [2*WIDTH-1:0] w_prod;

  assign w_signed = ~op[0];
  assign w_a_neg  = w_signed & rs_data[WIDTH-1];
  assign w_b_neg  = w_signed & rt_data[WIDTH-1];

  muldiv_sign_fix #(.WIDTH(WIDTH)) u_fix_a (.i_val(rs_data), .i_neg(w_a_neg), .o_val(w_a_mag));
  muldiv_sign_fix #(.WIDTH(WIDTH)) u_fix_b (.i_val(rt_data), .i_neg(w_b_neg), .o_val(w_b_mag));

  // Multiply: {hi_acc,lo_acc} shifts right, lo_acc starts as the multiplier.
  assign w_addend = r_lo_acc[0] ? r_m : '0;
  assign w_sum    = {1'b0, r_hi_acc} + {1'b0, w_addend};

  // Divide: hi_acc is the partial remainder, lo_acc shifts dividend out / quotient in.
  assign w_shl  = {r_hi_acc, r_lo_acc[WIDTH-1]};
  assign w_ge   = w_shl >= {1'b0, r_m};
  assign w_diff = w_shl[WIDTH-1:0] - r_m;

  muldiv_sign_fix #(.WIDTH(2*WIDTH)) u_fix_p (.i_val({r_hi_acc, r_lo_acc}), .i_neg(r_neg_q), .o_val(w_prod));
  muldiv_sign_fix #(.WIDTH(WIDTH))   u_fix_q (.i_val(r_lo_acc), .i_neg(r_neg_q), .o_val(w_quo));
  muldiv_sign_fix #(.WIDTH(WIDTH))   u_fix_r (.i_val(r_hi_acc), .i_neg(r_neg_r), .o_val(w_rem));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
      r_cnt    <= '0;
      r_m      <= '0;
      r_hi_acc <= '0;
      r_lo_acc <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
`ifdef MULDIV_DIVZERO_FLAG_EN
      r_div_zero <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
`ifdef MULDIV_DIVZERO_FLAG_EN
      r_div_zero <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state  <= ST_CALC;
            r_busy   <= 1'b1;
            r_is_div <= op[1];
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_dz     <= op[1] & (rt_data == '0);
            r_m      <= op[1] ? w_b_mag : w_a_mag;
            r_lo_acc <= op[1] ? w_a_mag : w_b_mag;
            r_hi_acc <= '0;
            r_cnt    <= '0;
          end else begin
            if (mthi) r_hi <= wdata;
            if (mtlo) r_lo <= wdata;
          end
        end
        ST_CALC: begin
          if (r_is_div) begin
            r_hi_acc <= w_ge ? w_diff : w_shl[WIDTH-1:0];
            r_lo_acc <= {r_lo_acc[WIDTH-2:0], w_ge};
          end else begin
            r_hi_acc <= w_sum[WIDTH:1];
            r_lo_acc <= {w_sum[0], r_lo_acc[WIDTH-1:1]};
          end
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(WIDTH-1)) r_state <= ST_FIX;
        end
        ST_FIX: begin
          if (r_is_div) begin
            r_hi <= w_rem;
            r_lo <= r_dz ? '1 : w_quo;
          end else begin
            r_hi <= w_prod[2*WIDTH-1:WIDTH];
            r_lo <= w_prod[WIDTH-1:0];
          end
          r_done  <= 1'b1;
`ifdef MULDIV_DIVZERO_FLAG_EN
          r_div_zero <= r_dz;
`endif
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;
`ifdef MULDIV_DIVZERO_FLAG_EN
  assign div_zero = r_div_zero;
`endif

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_muldiv_unit : directed vector bench for muldiv_unit           |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
module tb_muldiv_unit;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, mthi, mtlo;
  logic [1:0]  op;
  logic [31:0] rs_data, rt_data, wdata;
  logic        busy, done;
  logic [31:0] hi, lo;
`ifdef MULDIV_DIVZERO_FLAG_EN
  logic        div_zero;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
`ifdef MULDIV_DIVZERO_FLAG_EN
    .div_zero(div_zero),
`endif
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] rs, rt, ehi, elo;
    logic        edz;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Starting from sample point k0 after the start edge, wait for done (bounded).
  task automatic wait_done(input int k0, output int k, output int busy_low);
    k = k0;
    busy_low = 0;
    while (!done && k < 40) begin
      if (!busy) busy_low++;
      @(posedge clk); #1;
      k++;
    end
    if (!busy) busy_low++;
  endtask

  task automatic do_op(input vec_t v, input int idx);
    int k, bl;
    @(negedge clk);
    op = v.op; rs_data = v.rs; rt_data = v.rt; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(1, k, bl);
    chk($sformatf("v%0d_latency", idx), 64'(k), 64'd34);
    chk($sformatf("v%0d_busy", idx), 64'(bl), 64'd0);
    chk($sformatf("v%0d_hi", idx), 64'(hi), 64'(v.ehi));
    chk($sformatf("v%0d_lo", idx), 64'(lo), 64'(v.elo));
`ifdef MULDIV_DIVZERO_FLAG_EN
    chk($sformatf("v%0d_divzero", idx), 64'(div_zero), 64'(v.edz));
`endif
    @(posedge clk); #1;
    chk($sformatf("v%0d_done_pulse", idx), 64'(done), 64'd0);
    chk($sformatf("v%0d_idle", idx), 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, bl, done_cnt, busy_cnt;

    vecs[0]  = '{OP_MULT,  32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[1]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[4]  = '{OP_DIVU,  32'd100,      32'd0,        32'h00000064, 32'hFFFFFFFF, 1'b1};
    vecs[5]  = '{OP_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1};
    vecs[6]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[7]  = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[8]  = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0};
    vecs[9]  = '{OP_DIV,   32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002, 1'b0};
    vecs[10] = '{OP_MULT,  32'hFFFFFFFF, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFFB, 1'b0};
    vecs[11] = '{OP_MULTU, 32'd0,        32'hDEADBEEF, 32'h00000000, 32'h00000000, 1'b0};
    vecs[12] = '{OP_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0};

    reset = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    op = OP_MULT; rs_data = '0; rt_data = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    @(negedge clk); reset = 1'b0;

    for (int i = 0; i < 13; i++) do_op(vecs[i], i);

    // start and mthi during busy are both ignored
    @(negedge clk);
    op = OP_MULTU; rs_data = 32'd3; rt_data = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    @(negedge clk);
    op = OP_DIV; rs_data = 32'd100; rt_data = 32'd7; start = 1'b1; mthi = 1'b1; wdata = 32'h1234;
    @(posedge clk); #1;
    start = 1'b0; mthi = 1'b0;
    chk("ign_hi_hold", 64'(hi), 64'h1);
    wait_done(6, k, bl);
    chk("ign_latency", 64'(k), 64'd34);
    chk("ign_busy", 64'(bl), 64'd0);
    chk("ign_hi", 64'(hi), 64'd0);
    chk("ign_lo", 64'(lo), 64'hF);
    @(posedge clk); #1;

    @(negedge clk); mthi = 1'b1; wdata = 32'h1234;
    @(posedge clk); #1;
    chk("mthi_hi", 64'(hi), 64'h1234);
    chk("mthi_lo", 64'(lo), 64'hF);
    @(negedge clk); mthi = 1'b1; mtlo = 1'b1; wdata = 32'hABCD;
    @(posedge clk); #1;
    chk("mthilo_hi", 64'(hi), 64'hABCD);
    chk("mthilo_lo", 64'(lo), 64'hABCD);

    // mtlo alongside start is dropped; that DIV is then reset at CALC cycle 10
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b1; wdata = 32'h5555;
    op = OP_DIV; rs_data = 32'd1000; rt_data = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; mtlo = 1'b0;
    chk("mtlo_start_lo", 64'(lo), 64'hABCD);
    chk("mtlo_start_busy", 64'(busy), 64'd1);
    repeat (9) @(posedge clk);
    #1;
    chk("c10_busy", 64'(busy), 64'd1);
    chk("c10_hi_hold", 64'(hi), 64'hABCD);
    @(negedge clk); reset = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_hi", 64'(hi), 64'd0);
    chk("abort_lo", 64'(lo), 64'd0);
    @(negedge clk); reset = 1'b0; start = 1'b0;
    done_cnt = 0; busy_cnt = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
      if (busy) busy_cnt++;
    end
    chk("abort_no_done", 64'(done_cnt), 64'd0);
    chk("abort_no_busy", 64'(busy_cnt), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
